reg_dump_tx: RTL and testbench

REG_DUMP_TX -- requirements
Module: reg_dump_tx

---
 rtl/reg_dump_tx_pkg.sv | 15 +
 rtl/reg_dump_tx_uart_tx_byte.sv | 104 ++++++++++
 rtl/reg_dump_tx.sv | 85 ++++++++
 tb/tb_reg_dump_tx.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_dump_tx_pkg.sv
// Shared constants for the register-dump UART transmitter: serializer state
// encoding, default frame-sync byte and the number of bytes per dump frame.
package reg_dump_tx_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_START_BIT = 2'd1;
    localparam logic [1:0] ST_DATA_BITS = 2'd2;
    localparam logic [1:0] ST_STOP_BIT  = 2'd3;

    localparam logic [7:0] HEADER_BYTE_DEFAULT = 8'hA5;

    // Header byte plus the four register taps.
    localparam int unsigned FRAME_BYTES = 5;

endpackage

// File: rtl/reg_dump_tx_uart_tx_byte.sv
// 8N1 byte serializer. ready_o rises in the last stop-bit cycle, so a load
// taken then starts the next start bit with no idle gap between bytes.
//
// state        | meaning
// ST_IDLE      | line idle high, waiting for load_i
// ST_START_BIT | driving the start bit (0)
// ST_DATA_BITS | shifting data bits out LSB first
// ST_STOP_BIT  | driving the stop bit (1)
module uart_tx_byte
    import reg_dump_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [7:0] data_i,
    output logic       ready_o,
    output logic       tx_o
);

    localparam int unsigned    CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          tx_q, tx_d;
    logic          baud_end;

    assign baud_end = (baud_q == BAUD_LAST);
    assign ready_o  = (state_q == ST_IDLE) || ((state_q == ST_STOP_BIT) && baud_end);
    assign tx_o     = tx_q;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        if (state_q != ST_IDLE) begin
            baud_d = baud_end ? '0 : baud_q + 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                if (load_i) begin
                    state_d = ST_START_BIT;
                    shreg_d = data_i;
                    tx_d    = 1'b0;
                end
            end
            ST_START_BIT: begin
                if (baud_end) begin
                    state_d = ST_DATA_BITS;
                    tx_d    = shreg_q[0];
                end
            end
            ST_DATA_BITS: begin
                if (baud_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP_BIT;
                        bit_d   = '0;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shreg_d = {1'b0, shreg_q[7:1]};
                        tx_d    = shreg_q[1];
                    end
                end
            end
            ST_STOP_BIT: begin
                if (baud_end) begin
                    if (load_i) begin
                        state_d = ST_START_BIT;
                        shreg_d = data_i;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: rtl/reg_dump_tx.sv
// Register dump over UART: on start, snapshots four register taps and sends
// HEADER_BYTE followed by them as back-to-back 8N1 bytes.
module reg_dump_tx
    import reg_dump_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter logic [7:0]  HEADER_BYTE  = HEADER_BYTE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] Register1,
    input  logic [7:0] Register2,
    input  logic [7:0] Register3,
    input  logic [7:0] Register4,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [2:0]      byte_idx_q, byte_idx_d;
    logic [3:0][7:0] snap_q, snap_d;
    logic            ser_load;
    logic [7:0]      ser_data;
    logic            ser_ready;

    always_comb begin
        busy_d     = busy_q;
        done_d     = 1'b0;
        byte_idx_d = byte_idx_q;
        snap_d     = snap_q;
        ser_load   = 1'b0;
        ser_data   = HEADER_BYTE;
        if (!busy_q) begin
            if (start) begin
                ser_load   = 1'b1;
                busy_d     = 1'b1;
                byte_idx_d = '0;
                snap_d     = {Register4, Register3, Register2, Register1};
            end
        end else if (ser_ready) begin
            // byte_idx_q names the byte finishing now; snap_q[i] is byte i+1.
            if (byte_idx_q < 3'(FRAME_BYTES - 1)) begin
                ser_load   = 1'b1;
                ser_data   = snap_q[byte_idx_q[1:0]];
                byte_idx_d = byte_idx_q + 3'd1;
            end else begin
                busy_d     = 1'b0;
                done_d     = 1'b1;
                byte_idx_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            byte_idx_q <= '0;
            snap_q     <= '0;
        end else begin
            busy_q     <= busy_d;
            done_q     <= done_d;
            byte_idx_q <= byte_idx_d;
            snap_q     <= snap_d;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_ser (
        .clk_i  (clk),
        .rst_i  (rst),
        .load_i (ser_load),
        .data_i (ser_data),
        .ready_o(ser_ready),
        .tx_o   (tx)
    );

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_reg_dump_tx.sv
// Bench for reg_dump_tx: a per-cycle waveform model (queue of expected
// tx/busy/done values) checked every cycle, plus directed frame decodes.
module tb_reg_dump_tx;

    localparam logic [7:0] HDR = 8'hA5;
    localparam logic [2:0] IDLE_OUT = 3'b100;

    logic            clk = 1'b0;
    logic            rst;
    logic            start4, start2;
    logic [3:0][7:0] r4, r2;
    logic            tx4, busy4, done4, tx2, busy2, done2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reg_dump_tx #(.CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4),
        .Register1(r4[0]), .Register2(r4[1]), .Register3(r4[2]), .Register4(r4[3]),
        .tx(tx4), .busy(busy4), .done(done4)
    );

    reg_dump_tx #(.CLKS_PER_BIT(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2),
        .Register1(r2[0]), .Register2(r2[1]), .Register3(r2[2]), .Register4(r2[3]),
        .tx(tx2), .busy(busy2), .done(done2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: each entry is the expected {tx, busy, done} for one cycle.
    logic [2:0] q0[$];
    logic [2:0] q1[$];
    logic [2:0] cur0 = IDLE_OUT;
    logic [2:0] cur1 = IDLE_OUT;
    bit         chk_en = 1'b0;

    task automatic push_exp(input int d, input logic [2:0] v);
        if (d == 0) q0.push_back(v);
        else        q1.push_back(v);
    endtask

    task automatic push_frame(input int d, input int cpb, input logic [3:0][7:0] regs);
        logic [7:0] b;
        logic [9:0] f;
        for (int k = 0; k < 5; k++) begin
            if (k == 0) b = HDR;
            else        b = regs[k-1];
            f = {1'b1, b, 1'b0};
            for (int j = 0; j < 10; j++)
                for (int c = 0; c < cpb; c++)
                    push_exp(d, {f[j], 2'b10});
        end
        push_exp(d, 3'b101);
    endtask

    always @(posedge clk) begin
        if (rst) begin
            q0.delete();
            q1.delete();
            cur0 = IDLE_OUT;
            cur1 = IDLE_OUT;
        end else begin
            if (!cur0[1] && start4) push_frame(0, 4, r4);
            if (!cur1[1] && start2) push_frame(1, 2, r2);
            cur0 = (q0.size() > 0) ? q0.pop_front() : IDLE_OUT;
            cur1 = (q1.size() > 0) ? q1.pop_front() : IDLE_OUT;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_dut4", {tx4, busy4, done4}, cur0);
            chk("model_dut2", {tx2, busy2, done2}, cur1);
        end
    end

    task automatic set_start(input int d, input logic v);
        if (d == 0) start4 = v;
        else        start2 = v;
    endtask

    // Starts a dump, records it from the first start-bit cycle, then decodes.
    task automatic run_frame(input int d, input logic [39:0] exp, input int chg_at,
                             input logic [7:0] chg_val, input int hold_from, input int hold_to);
        int         cpb;
        int         n;
        int         busy_n;
        int         done_n;
        int         done_pos;
        int         base;
        logic       tx_rec [0:204];
        logic [7:0] by;
        cpb      = (d == 0) ? 4 : 2;
        n        = 50 * cpb + 5;
        busy_n   = 0;
        done_n   = 0;
        done_pos = -1;
        set_start(d, 1'b1);
        @(negedge clk);
        set_start(d, 1'b0);
        for (int i = 0; i < n; i++) begin
            tx_rec[i] = (d == 0) ? tx4 : tx2;
            if ((d == 0) ? busy4 : busy2) busy_n++;
            if ((d == 0) ? done4 : done2) begin
                done_n++;
                done_pos = i;
            end
            if (i == chg_at) r4[1] = chg_val;
            set_start(d, (i >= hold_from) && (i < hold_to));
            @(negedge clk);
        end
        set_start(d, 1'b0);
        for (int k = 0; k < 5; k++) begin
            base = k * 10 * cpb;
            for (int b = 0; b < 8; b++) by[b] = tx_rec[base + (1 + b) * cpb + cpb / 2];
            chk($sformatf("d%0d_startbit%0d", d, k), 32'(tx_rec[base + cpb / 2]), 32'd0);
            chk($sformatf("d%0d_byte%0d", d, k), 32'(by), 32'(exp[39 - 8 * k -: 8]));
            chk($sformatf("d%0d_stopbit%0d", d, k), 32'(tx_rec[base + 9 * cpb + cpb / 2]), 32'd1);
        end
        chk($sformatf("d%0d_busy_cycles", d), busy_n, 50 * cpb);
        chk($sformatf("d%0d_done_count", d), done_n, 1);
        chk($sformatf("d%0d_done_pos", d), done_pos, 50 * cpb);
    endtask

    initial begin
        int d1;
        int d2;
        int dn;
        rst    = 1'b1;
        start4 = 1'b0;
        start2 = 1'b0;
        r4     = '0;
        r2     = '0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("reset_state", {tx4, busy4, done4}, IDLE_OUT);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        r4 = {8'h04, 8'h03, 8'h02, 8'h01};
        run_frame(0, 40'hA5_01_02_03_04, -1, 8'h00, -1, -1);

        r4 = {8'h44, 8'h33, 8'h3C, 8'h11};
        run_frame(0, 40'hA5_11_3C_33_44, 10, 8'hFF, -1, -1);

        r4 = {8'hC3, 8'h5A, 8'h96, 8'h80};
        run_frame(0, 40'hA5_80_96_5A_C3, -1, 8'h00, 50, 100);

        // Reset in the middle of a dump.
        r4 = {8'h0F, 8'hF0, 8'h12, 8'h34};
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        repeat (60) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_tx", 32'(tx4), 32'd1);
        chk("rst_busy", 32'(busy4), 32'd0);
        dn = 0;
        for (int i = 0; i < 250; i++) begin
            if (done4) dn++;
            @(negedge clk);
        end
        chk("rst_no_done", dn, 0);
        r4 = {8'h44, 8'h33, 8'h22, 8'h11};
        run_frame(0, 40'hA5_11_22_33_44, -1, 8'h00, -1, -1);

        // Start in the done cycle.
        d1 = -1;
        d2 = -1;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (done4) begin
                if (d1 < 0) begin
                    d1 = i;
                    start4 = 1'b1;
                end else if (d2 < 0) begin
                    d2 = i;
                end
            end
            @(negedge clk);
            start4 = 1'b0;
            if (d2 >= 0) break;
        end
        chk("b2b_first_done", d1, 200);
        chk("b2b_done_gap", d2 - d1, 201);
        repeat (3) @(negedge clk);

        r2 = {8'h55, 8'hAA, 8'h00, 8'hFF};
        run_frame(1, 40'hA5_FF_00_AA_55, -1, 8'h00, -1, -1);

        // Random starts, register churn and occasional resets on both instances.
        for (int i = 0; i < 3000; i++) begin
            r4     = $urandom;
            r2     = $urandom;
            start4 = ($urandom_range(0, 19) == 0);
            start2 = ($urandom_range(0, 9) == 0);
            rst    = ($urandom_range(0, 699) == 0);
            @(negedge clk);
        end
        rst    = 1'b0;
        start4 = 1'b0;
        start2 = 1'b0;
        repeat (300) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
